csa_accum_ctrl: RTL and testbench

CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

---
 rtl/csa_accum_ctrl_pkg.sv | 14 +
 rtl/csa_accum_ctrl_if.sv | 29 ++
 rtl/csa_accum_ctrl_csa_vec.sv | 17 +
 rtl/csa_accum_ctrl.sv | 143 ++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_accum_ctrl_pkg.sv
// csa_accum_ctrl shared types: FSM state encoding and count width.
// Imported by the interface, the top and the testbench side.
package csa_accum_ctrl_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Job/operand/result bundle between a producer-consumer and the controller.
// master = producer/consumer side, slave = csa_accum_ctrl side.
interface csa_accum_ctrl_if
  import csa_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
);
  logic               start;
  logic [COUNT_W-1:0] count;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               busy;
  logic               out_valid;
  logic [ACC_W-1:0]   out_sum;
  logic               out_ack;
  logic               ovf;

  modport master (
    output start, count, in_valid, in_data, out_ack,
    input  in_ready, busy, out_valid, out_sum, ovf
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ack,
    output in_ready, busy, out_valid, out_sum, ovf
  );
endinterface

// File: rtl/csa_accum_ctrl_csa_vec.sv
// csa_vec: bitwise 3:2 compressor (sum and unshifted majority).
// Purely combinational; the caller applies the carry shift.
module csa_vec #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_maj
);
  // sum and majority per bit position
  always_comb begin
    o_s   = i_a ^ i_b ^ i_c;
    o_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  end
endmodule

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator: CSA per operand, then bit-serial resolve.
// Optional overflow flag enabled by macro CSA_ACC_OVF_EN.
module csa_accum_ctrl
  import csa_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input logic             clk,
  input logic             rst,
  csa_accum_ctrl_if.slave bus
);
  localparam int BW = (ACC_W > 1) ? $clog2(ACC_W) : 1;

  state_e             r_state;
  logic [ACC_W-1:0]   r_s;
  logic [ACC_W-1:0]   r_c;
  logic [ACC_W-1:0]   r_sum;
  logic [COUNT_W-1:0] r_cnt;
  logic [BW-1:0]      r_bit;
  logic               r_cy;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_out_valid;

  logic [ACC_W-1:0]   w_d;
  logic [ACC_W-1:0]   w_xs;
  logic [ACC_W-1:0]   w_maj;
  logic [ACC_W-1:0]   w_cnext;
  logic               w_xfer;
  logic               w_fa_s;
  logic               w_fa_c;
  logic               w_last_bit;

  assign w_d        = ACC_W'(bus.in_data);
  assign w_xfer     = bus.in_valid & r_in_ready;
  assign w_cnext    = {w_maj[ACC_W-2:0], 1'b0};
  assign w_last_bit = (r_bit == BW'(ACC_W - 1));

  // serial full adder on the current LSBs of S and C
  assign w_fa_s = r_s[0] ^ r_c[0] ^ r_cy;
  assign w_fa_c = (r_s[0] & r_c[0]) |
                  (r_s[0] & r_cy) |
                  (r_c[0] & r_cy);

  csa_vec #(.W(ACC_W)) u_csa (
    .i_a   (r_s),
    .i_b   (r_c),
    .i_c   (w_d),
    .o_s   (w_xs),
    .o_maj (w_maj)
  );

`ifdef CSA_ACC_OVF_EN
  logic r_ovf;
  assign bus.ovf = r_ovf;
`else
  logic w_unused_msb;
  assign w_unused_msb = w_maj[ACC_W-1];
  assign bus.ovf      = 1'b0;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;

  // job FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_cy        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_cnt  <= bus.count;
            r_s    <= '0;
            r_c    <= '0;
            r_cy   <= 1'b0;
            r_bit  <= '0;
            r_busy <= 1'b1;
`ifdef CSA_ACC_OVF_EN
            r_ovf  <= 1'b0;
`endif
            if (bus.count != '0) begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              r_state    <= RESOLVE;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_s   <= w_xs;
            r_c   <= w_cnext;
            r_cnt <= r_cnt - 1'b1;
`ifdef CSA_ACC_OVF_EN
            if (w_maj[ACC_W-1]) r_ovf <= 1'b1;
`endif
            if (r_cnt == COUNT_W'(1)) begin
              r_state    <= RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_sum <= {w_fa_s, r_sum[ACC_W-1:1]};
          r_s   <= r_s >> 1;
          r_c   <= r_c >> 1;
          r_cy  <= w_fa_c;
          r_bit <= r_bit + 1'b1;
          if (w_last_bit) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`ifdef CSA_ACC_OVF_EN
            if (w_fa_c) r_ovf <= 1'b1;
`endif
          end
        end
        DONE: begin
          if (bus.out_ack) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl: ACC_W=8 main DUT, ACC_W=6 ovf DUT.
// Expected ovf on the ACC_W=6 DUT depends on CSA_ACC_OVF_EN.
module tb_csa_accum_ctrl;
`ifdef CSA_ACC_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ack = 1'b0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  csa_accum_ctrl_if #(.WIDTH(4), .ACC_W(8)) ifa ();
  csa_accum_ctrl_if #(.WIDTH(4), .ACC_W(6)) ifb ();

  assign ifa.start    = start & ~sel;
  assign ifa.count    = count;
  assign ifa.in_valid = in_valid & ~sel;
  assign ifa.in_data  = in_data;
  assign ifa.out_ack  = out_ack & ~sel;
  assign ifb.start    = start & sel;
  assign ifb.count    = count;
  assign ifb.in_valid = in_valid & sel;
  assign ifb.in_data  = in_data;
  assign ifb.out_ack  = out_ack & sel;

  csa_accum_ctrl #(.WIDTH(4), .ACC_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  csa_accum_ctrl #(.WIDTH(4), .ACC_W(6)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  wire       m_ready = sel ? ifb.in_ready : ifa.in_ready;
  wire       m_valid = sel ? ifb.out_valid : ifa.out_valid;
  wire       m_busy  = sel ? ifb.busy : ifa.busy;
  wire [7:0] m_sum   = sel ? {2'b00, ifb.out_sum} : ifa.out_sum;

  typedef struct {
    int sum;
    int ovf;
    int t;
    int lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ca;
  exp_t cb;
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  int   rdy_cnt = 0;
  int   xfer_cnt = 0;
  int   opv[16];
  bit   pva = 1'b0;
  bit   pvb = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (m_ready) rdy_cnt++;
    if (m_ready && in_valid) xfer_cnt++;
  end

  // monitor: main DUT results
  always @(negedge clk) begin
    if (ifa.out_valid && !pva) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_result", 1, 0);
      end else begin
        ca = qa.pop_front();
        chk("a_sum", int'(ifa.out_sum), ca.sum);
        chk("a_ovf", int'(ifa.ovf), ca.ovf);
        chk("a_latency", ncyc - ca.t, ca.lat);
      end
    end else if (ifa.out_valid) begin
      chk("a_sum_stable", int'(ifa.out_sum), ca.sum);
    end
    pva = ifa.out_valid;
  end

  // monitor: ACC_W=6 DUT results
  always @(negedge clk) begin
    if (ifb.out_valid && !pvb) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_result", 1, 0);
      end else begin
        cb = qb.pop_front();
        chk("b_sum", int'(ifb.out_sum), cb.sum);
        chk("b_ovf", int'(ifb.ovf), cb.ovf);
        chk("b_latency", ncyc - cb.t, cb.lat);
      end
    end else if (ifb.out_valid) begin
      chk("b_sum_stable", int'(ifb.out_sum), cb.sum);
    end
    pvb = ifb.out_valid;
  end

  task automatic job(input bit s, input int n, input int gap,
                     input int esum, input int eovf,
                     input int hold, input bit pulse);
    int   t;
    int   r0;
    int   x0;
    bit   got;
    exp_t e;
    sel = s;
    @(posedge clk); #1;
    start = 1'b1;
    count = n[3:0];
    r0 = rdy_cnt;
    x0 = xfer_cnt;
    @(negedge clk);
    t = ncyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = opv[i][3:0];
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (m_ready) begin
          got = 1'b1;
          t = ncyc;
        end
        @(posedge clk); #1;
      end
      if (!got) chk("xfer_timeout", 0, 1);
      in_valid = 1'b0;
      if (i != n - 1) repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    e.sum = esum;
    e.ovf = eovf;
    e.t   = t;
    e.lat = s ? 7 : 9;
    if (s) qb.push_back(e);
    else   qa.push_back(e);
    got = 1'b0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (m_valid) got = 1'b1;
    end
    chk("done_reached", int'(got), 1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      start = pulse && (k == 1);
      count = 4'd5;
      @(negedge clk);
      chk("done_hold_valid", int'(m_valid), 1);
      chk("done_hold_busy", int'(m_busy), 1);
    end
    @(posedge clk); #1;
    start   = 1'b0;
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(m_busy), 0);
    chk("idle_valid", int'(m_valid), 0);
    chk("idle_sum_kept", int'(m_sum), esum);
    chk("transfers", xfer_cnt - x0, n);
    if (n == 0) chk("no_in_ready", rdy_cnt - r0, 0);
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_ready", int'(ifa.in_ready), 0);
    chk("rst_valid", int'(ifa.out_valid), 0);
    chk("rst_sum", int'(ifa.out_sum), 0);
    chk("rst_ovf", int'(ifa.ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    opv[0] = 15; opv[1] = 15; opv[2] = 15;
    job(1'b0, 3, 0, 45, 0, 0, 1'b0);

    job(1'b0, 0, 0, 0, 0, 0, 1'b0);

    opv[0] = 1; opv[1] = 2; opv[2] = 3; opv[3] = 4;
    job(1'b0, 4, 1, 10, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) opv[i] = 15;
    job(1'b0, 15, 0, 225, 0, 0, 1'b0);

    opv[0] = 9; opv[1] = 6;
    job(1'b0, 2, 0, 15, 0, 5, 1'b1);

    sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    count = 4'd3;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(ifa.busy), 0);
    chk("mid_rst_ready", int'(ifa.in_ready), 0);
    chk("mid_rst_valid", int'(ifa.out_valid), 0);
    chk("mid_rst_sum", int'(ifa.out_sum), 0);
    chk("mid_rst_ovf", int'(ifa.ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    opv[0] = 7;
    job(1'b0, 1, 0, 7, 0, 0, 1'b0);

    for (int i = 0; i < 5; i++) opv[i] = 15;
    job(1'b1, 5, 0, 11, int'(OVF_ON), 0, 1'b0);

    opv[0] = 1;
    job(1'b1, 1, 0, 1, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
